aesl_dataflow_deadlock_monitor: RTL

Parametrised simulation-side deadlock monitor for HLS dataflow regions with N_PROC processes.
- Tracks how long each process has been blocked.
- Chases the "waits-on" pointer graph one hop per cycle to confirm a cyclic wait.
- Latches and reports the cycle and keeps per-process in-flight transaction counts.
- Sits beside the top-level dataflow instance in the testbench; successor to the fixed 3-process detector.

---
 rtl/aesl_dl_pkg.sv | 30 +++
 rtl/aesl_stall_counter.sv | 33 +++
 rtl/aesl_dataflow_deadlock_monitor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/aesl_dl_pkg.sv
// Shared types and helpers for the dataflow deadlock monitor.
//   dl_state_e : monitor FSM states
//   idx_w()    : process index width for a given process count
//   onehot()   : one-hot vector (MAX_PROC wide) for a process index
package aesl_dl_pkg;

  localparam int unsigned MAX_PROC   = 64;
  localparam int unsigned MAX_IDX_W  = $clog2(MAX_PROC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHASE    = 2'd1,
    DETECTED = 2'd2
  } dl_state_e;

  // At least one bit so a 2-process region still has an index signal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Callers truncate the result to their own process count.
  function automatic logic [MAX_PROC-1:0] onehot(input int unsigned idx,
                                                 input int unsigned n);
    logic [MAX_PROC-1:0] v;
    v = '0;
    if (idx < n) v[MAX_IDX_W'(idx)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/aesl_stall_counter.sv
// Per-process blocked-cycle counter.
//   clock, reset : clock and async active-low reset
//   blk          : process blocked this cycle
//   done         : process completed this cycle (a completing process is not stalled)
//   stuck        : counter has saturated at STALL_THRESH (decode of the register)
module aesl_stall_counter #(
  parameter int unsigned STALL_THRESH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic blk,
  input  logic done,
  output logic stuck
);

  localparam int unsigned CW = $clog2(STALL_THRESH + 1);

  logic [CW-1:0] cnt;

  // Count consecutive blocked cycles, saturating; any unblocked cycle restarts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (blk && !done) begin
      if (cnt != CW'(STALL_THRESH)) cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign stuck = (cnt == CW'(STALL_THRESH));

endmodule

// File: rtl/aesl_dataflow_deadlock_monitor.sv
// Simulation-side deadlock monitor for an N_PROC-process dataflow region.
// Confirms a cyclic wait by following proc_wait_on one hop per cycle through
// stuck processes, then latches the result until reset. Also keeps per-process
// in-flight (start minus done) counts.
//   clock, reset   : clock and async active-low reset
//   all_finish     : region finished; no new detection starts or continues
//   proc_blk       : per-process blocked flags
//   proc_wait_on   : per-process index of the process being waited on
//   start_pulse    : per-process start accepted
//   done_pulse     : per-process completion
//   dl_detect_out  : sticky deadlock flag
//   dl_report      : one-cycle pulse on confirmation
//   dl_origin      : process that closed the cycle
//   dl_cycle_mask  : processes visited on the confirming chase
//   dl_cycle_len   : hops taken to close the cycle
//   inflight       : per-process in-flight counts, process i at [i*CNT_W +: CNT_W]
//   cnt_err        : sticky in-flight saturation/underflow flag
module aesl_dataflow_deadlock_monitor
  import aesl_dl_pkg::*;
#(
  parameter  int unsigned N_PROC       = 3,
  parameter  int unsigned STALL_THRESH = 16,
  parameter  int unsigned CNT_W        = 16,
  localparam int unsigned IDX_W        = idx_w(N_PROC)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      all_finish,
  input  logic [N_PROC-1:0]         proc_blk,
  input  logic [N_PROC*IDX_W-1:0]   proc_wait_on,
  input  logic [N_PROC-1:0]         start_pulse,
  input  logic [N_PROC-1:0]         done_pulse,
  output logic                      dl_detect_out,
  output logic                      dl_report,
  output logic [IDX_W-1:0]          dl_origin,
  output logic [N_PROC-1:0]         dl_cycle_mask,
  output logic [IDX_W:0]            dl_cycle_len,
  output logic [N_PROC*CNT_W-1:0]   inflight,
  output logic                      cnt_err
);

  logic [N_PROC-1:0] stuck;
  logic [IDX_W-1:0]  wait_arr [N_PROC];
  logic [CNT_W-1:0]  inf_q    [N_PROC];
  logic [N_PROC-1:0] err_evt;

  for (genvar g = 0; g < N_PROC; g++) begin : g_proc
    aesl_stall_counter #(.STALL_THRESH(STALL_THRESH)) u_stall (
      .clock (clock),
      .reset (reset),
      .blk   (proc_blk[g]),
      .done  (done_pulse[g]),
      .stuck (stuck[g])
    );

    assign wait_arr[g] = proc_wait_on[g*IDX_W +: IDX_W];

    // Error when a lone start hits all-ones or a lone done hits zero.
    assign err_evt[g] = (start_pulse[g] && !done_pulse[g] && (inf_q[g] == '1)) ||
                        (done_pulse[g] && !start_pulse[g] && (inf_q[g] == '0));

    // In-flight count; holds on overflow/underflow instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        inf_q[g] <= '0;
      end else if (start_pulse[g] && !done_pulse[g] && (inf_q[g] != '1)) begin
        inf_q[g] <= inf_q[g] + CNT_W'(1);
      end else if (done_pulse[g] && !start_pulse[g] && (inf_q[g] != '0)) begin
        inf_q[g] <= inf_q[g] - CNT_W'(1);
      end
    end

    assign inflight[g*CNT_W +: CNT_W] = inf_q[g];
  end

  // Sticky counter error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_err <= 1'b0;
    else if (|err_evt) cnt_err <= 1'b1;
  end

  dl_state_e         state;
  logic [IDX_W-1:0]  cur_q;
  logic [IDX_W-1:0]  origin_q;
  logic [IDX_W-1:0]  rr_q;
  logic [N_PROC-1:0] visited_q;
  logic [IDX_W:0]    len_q;

  logic [IDX_W-1:0]  nxt;
  logic              nxt_ok;
  logic              stuck_cur;
  logic              stuck_nxt;
  logic              visited_nxt;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  rr_wrap;

  // Hop decode; an out-of-range pointer reads as "not stuck, not visited".
  always_comb begin
    nxt         = wait_arr[cur_q];
    nxt_ok      = ({1'b0, nxt} < (IDX_W+1)'(N_PROC));
    stuck_cur   = stuck[cur_q];
    stuck_nxt   = nxt_ok && stuck[nxt];
    visited_nxt = nxt_ok && visited_q[nxt];
  end

  // First stuck process at or after rr_q, wrapping; gives each stuck process a turn.
  always_comb begin : cand_sel
    int unsigned j;
    logic        hit;
    cand = '0;
    hit  = 1'b0;
    for (int unsigned k = 0; k < N_PROC; k++) begin
      j = 32'(rr_q) + k;
      if (j >= N_PROC) j = j - N_PROC;
      if (!hit && stuck[IDX_W'(j)]) begin
        cand = IDX_W'(j);
        hit  = 1'b1;
      end
    end
  end

  // Start pointer for the next search: one past the aborted chase's origin.
  always_comb begin : rr_next
    int unsigned inc;
    inc     = 32'(origin_q) + 1;
    rr_wrap = (inc >= N_PROC) ? '0 : IDX_W'(inc);
  end

  // Chase FSM with registered report outputs; DETECTED is terminal until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cur_q         <= '0;
      origin_q      <= '0;
      rr_q          <= '0;
      visited_q     <= '0;
      len_q         <= '0;
      dl_detect_out <= 1'b0;
      dl_report     <= 1'b0;
      dl_origin     <= '0;
      dl_cycle_mask <= '0;
      dl_cycle_len  <= '0;
    end else begin
      dl_report <= 1'b0;
      case (state)
        IDLE: begin
          if (!all_finish && (|stuck)) begin
            cur_q     <= cand;
            origin_q  <= cand;
            visited_q <= N_PROC'(onehot(32'(cand), N_PROC));
            len_q     <= '0;
            state     <= CHASE;
          end
        end
        CHASE: begin
          if (all_finish || !nxt_ok || !stuck_cur || !stuck_nxt) begin
            rr_q  <= rr_wrap;
            state <= IDLE;
          end else if (visited_nxt) begin
            dl_detect_out <= 1'b1;
            dl_report     <= 1'b1;
            dl_origin     <= nxt;
            dl_cycle_mask <= visited_q;
            dl_cycle_len  <= len_q + (IDX_W+1)'(1);
            state         <= DETECTED;
          end else begin
            visited_q <= visited_q | N_PROC'(onehot(32'(nxt), N_PROC));
            cur_q     <= nxt;
            len_q     <= len_q + (IDX_W+1)'(1);
          end
        end
        DETECTED: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
